// File: rtl/counter_button_ctrl_pkg.sv
// Shared types and constants for the counter button front-end.
// Debounce FSM states plus a short acceptance window used by simulation benches.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    DB_ZERO  = 2'd0,
    DB_WAIT1 = 2'd1,
    DB_ONE   = 2'd2,
    DB_WAIT0 = 2'd3
  } db_state_t;

  localparam int DB_TICKS_SIM = 4;

endpackage

// File: rtl/counter_button_ctrl_debounce_edge.sv
// One raw button: 2-flop synchroniser, debounce FSM with stability timer,
// and a single-cycle rise pulse on acceptance of a press.
module debounce_edge
  import counter_ctrl_pkg::*;
#(
  parameter int DB_TICKS = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int TW = $clog2(DB_TICKS);
  localparam logic [TW-1:0] T_LAST = TW'(DB_TICKS - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  db_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          s;

  assign s = sync2_q;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    state_d = state_q;
    timer_d = timer_q;
    rise    = 1'b0;
    case (state_q)
      DB_ZERO: begin
        if (s) begin
          state_d = DB_WAIT1;
          timer_d = '0;
        end
      end
      DB_WAIT1: begin
        if (!s) begin
          state_d = DB_ZERO;
        end else if (timer_q == T_LAST) begin
          state_d = DB_ONE;
          rise    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DB_ONE: begin
        if (!s) begin
          state_d = DB_WAIT0;
          timer_d = '0;
        end
      end
      DB_WAIT0: begin
        if (s) begin
          state_d = DB_ONE;
        end else if (timer_q == T_LAST) begin
          state_d = DB_ZERO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = DB_ZERO;
    endcase
  end

  assign level = (state_q == DB_ONE) || (state_q == DB_WAIT0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_ZERO;
      timer_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/counter_button_ctrl.sv
// Button front-end for the universal binary counter: debounces four buttons,
// arbitrates clr > load > count, optionally saturates, and registers commands.
module counter_button_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int N        = 8,
  parameter int DB_TICKS = 2_000_000,
  parameter int SATURATE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_clr,
  input  logic         btn_load,
  input  logic [N-1:0] sw,
  input  logic         max_flag,
  input  logic         min_flag,
  output logic         syn_clr,
  output logic         load,
  output logic [N-1:0] d,
  output logic         en,
  output logic         up
);

  logic [3:0] lvl_unused;
  logic       rise_up, rise_down, rise_clr, rise_load;
  logic       lvl_unused_red;

  debounce_edge #(.DB_TICKS(DB_TICKS)) u_db_up (
    .clk(clk), .reset(reset), .raw(btn_up),   .level(lvl_unused[0]), .rise(rise_up));
  debounce_edge #(.DB_TICKS(DB_TICKS)) u_db_down (
    .clk(clk), .reset(reset), .raw(btn_down), .level(lvl_unused[1]), .rise(rise_down));
  debounce_edge #(.DB_TICKS(DB_TICKS)) u_db_clr (
    .clk(clk), .reset(reset), .raw(btn_clr),  .level(lvl_unused[2]), .rise(rise_clr));
  debounce_edge #(.DB_TICKS(DB_TICKS)) u_db_load (
    .clk(clk), .reset(reset), .raw(btn_load), .level(lvl_unused[3]), .rise(rise_load));

  assign lvl_unused_red = ^lvl_unused;

  logic [N-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [N-1:0] d_q, d_d;
  logic         syn_clr_q, syn_clr_d;
  logic         load_q, load_d;
  logic         en_q, en_d;
  logic         up_q, up_d;
  logic         count_req, sat_drop;

  always_comb begin
    sw_s1_d   = sw;
    sw_s2_d   = sw_s1_q;
    syn_clr_d = 1'b0;
    load_d    = 1'b0;
    en_d      = 1'b0;
    up_d      = up_q;
    d_d       = d_q;
    // Simultaneous up and down rises cancel; saturation uses the flags seen this cycle.
    count_req = rise_up ^ rise_down;
    sat_drop  = (SATURATE != 0) &&
                ((rise_up && max_flag) || (rise_down && min_flag));
    if (rise_clr) begin
      syn_clr_d = 1'b1;
    end else if (rise_load) begin
      load_d = 1'b1;
      d_d    = sw_s2_q;
    end else if (count_req && !sat_drop) begin
      en_d = 1'b1;
      up_d = rise_up;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      d_q       <= '0;
      syn_clr_q <= 1'b0;
      load_q    <= 1'b0;
      en_q      <= 1'b0;
      up_q      <= 1'b0;
    end else begin
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      d_q       <= d_d;
      syn_clr_q <= syn_clr_d;
      load_q    <= load_d;
      en_q      <= en_d;
      up_q      <= up_d;
    end
  end

  assign syn_clr = syn_clr_q;
  assign load    = load_q;
  assign en      = en_q;
  assign up      = up_q;
  assign d       = d_q;

endmodule
